// File: rtl/ones_pattern_generator.sv
// ones_pattern_generator: walks every 7-bit word with exactly K ones in
// ascending order, one word per valid/ready transfer. The successor of each
// word is produced combinationally with Gosper's constant-weight increment,
// so a new word is presented on the edge right after every transfer.
module ones_pattern_generator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] count_in,
  output logic       busy,
  output logic [6:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       last,
  output logic [5:0] index,
  output logic       done
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state, state_nxt;
  logic [2:0] k_q;
  logic [6:0] word_q;
  logic [5:0] idx_q;
  logic       done_q;

  logic       xfer;
  logic       at_final;
  logic       seq_end;
  logic [7:0] first_w;
  logic [7:0] final_w;

  // Gosper intermediates, all 8 bits wide so the carry out of bit 6 is kept
  logic [7:0] g_x, g_c, g_r, g_t, g_n;
  logic [2:0] g_tz;

  assign xfer = (state == EMIT) && ready;

  // Lowest word with K ones for the count being latched: (1<<K)-1
  assign first_w = (8'd1 << count_in) - 8'd1;

  // Highest word with K ones for the latched count: the K ones packed to the top
  always_comb begin
    final_w = ((8'd1 << k_q) - 8'd1) << (3'd7 - k_q);
  end

  assign at_final = (word_q == final_w[6:0]);

  // Successor: c = x & -x; r = x + c; next = r | (((r ^ x) >> 2) >> tz(c))
  always_comb begin
    g_x  = {1'b0, word_q};
    g_c  = g_x & (~g_x + 8'd1);
    g_r  = g_x + g_c;
    g_tz = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (g_c[i]) g_tz = i[2:0];
    end
    g_t  = ((g_r ^ g_x) >> 2) >> g_tz;
    g_n  = g_r | g_t;
  end

  // A carry out of bit 6 also means the constant-weight space is exhausted
  assign seq_end = at_final | g_n[7];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start is only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)           state_nxt = EMIT;
      EMIT:    if (xfer && seq_end) state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Datapath: latch K and first word on start, advance on each transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= 3'd0;
      word_q <= 7'd0;
      idx_q  <= 6'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          k_q    <= count_in;
          word_q <= first_w[6:0];
          idx_q  <= 6'd0;
        end
      end else if (xfer) begin
        if (seq_end) begin
          word_q <= 7'd0;
          idx_q  <= 6'd0;
          done_q <= 1'b1;
        end else begin
          word_q <= g_n[6:0];
          idx_q  <= idx_q + 6'd1;
        end
      end
    end
  end

  // Outputs decoded from state; word and index come straight from registers
  always_comb begin
    valid    = (state == EMIT);
    busy     = (state == EMIT);
    last     = (state == EMIT) && at_final;
    data_out = word_q;
    index    = idx_q;
    done     = done_q;
  end

endmodule
